// File: rtl/freq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | freq_pkg : shared constants and FSM encoding for the frequency meter      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package freq_pkg;

  localparam int CLK50M_HZ        = 50_000_000;
  localparam int GATE_CYCLES_DEF  = 50_000_000;
  localparam int CNT_W_DEF        = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GATE  = 2'd1,
    LATCH = 2'd2
  } fm_state_t;

endpackage
`default_nettype wire

// File: rtl/freq_meter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | freq_meter_if : measurement control/result bundle of freq_meter           |
// | Period signals exist only with FREQ_METER_PERIOD_EN.   Rev 1.0            |
// +--------------------------------------------------------------------------+
interface freq_meter_if #(
  parameter int CNT_W = freq_pkg::CNT_W_DEF
);

  logic             en;
  logic             sig_in;
  logic [CNT_W-1:0] freq_out;
  logic             valid;
  logic             ovf;
`ifdef FREQ_METER_PERIOD_EN
  logic [CNT_W-1:0] period_out;
  logic             period_valid;

  modport master (output en, sig_in, input freq_out, valid, ovf, period_out, period_valid);
  modport slave  (input en, sig_in, output freq_out, valid, ovf, period_out, period_valid);
`else
  modport master (output en, sig_in, input freq_out, valid, ovf);
  modport slave  (input en, sig_in, output freq_out, valid, ovf);
`endif

endinterface
`default_nettype wire

// File: rtl/edge_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | edge_sync : 2-flop synchronizer plus rising-edge detect (rise = s2&~s3)   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module edge_sync (
  input  wire logic clk50M,
  input  wire logic rst_n,
  input  wire logic d_async,
  output logic      rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk50M) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= d_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign rise = r_s2 & ~r_s3;

endmodule
`default_nettype wire

// File: rtl/freq_meter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | freq_meter : counts sig_in rising edges per gate window of clk50M cycles  |
// | Optional period measurement: FREQ_METER_PERIOD_EN.     Rev 1.0            |
// +--------------------------------------------------------------------------+
module freq_meter
  import freq_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  wire logic   clk50M,
  input  wire logic   rst_n,
  freq_meter_if.slave bus
);

  localparam int             GATE_W      = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] c_gate_last = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  c_cnt_max   = '1;

  fm_state_t        r_state;
  logic [GATE_W-1:0] r_gate_cnt;
  logic [CNT_W-1:0] r_edge_cnt;
  logic             r_sat;
  logic [CNT_W-1:0] r_freq;
  logic             r_valid;
  logic             r_ovf;
  logic             w_rise;

  edge_sync u_sync (
    .clk50M  (clk50M),
    .rst_n   (rst_n),
    .d_async (bus.sig_in),
    .rise    (w_rise)
  );

  always_ff @(posedge clk50M) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_sat      <= 1'b0;
      r_freq     <= '0;
      r_valid    <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_gate_cnt <= '0;
          r_edge_cnt <= '0;
          r_sat      <= 1'b0;
          if (bus.en) r_state <= GATE;
        end
        GATE: begin
          if (!bus.en) begin
            // Abort: partial count is discarded, published result untouched.
            r_state    <= IDLE;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_sat      <= 1'b0;
          end else begin
            if (w_rise) begin
              if (r_edge_cnt == c_cnt_max) r_sat <= 1'b1;
              else                         r_edge_cnt <= r_edge_cnt + 1'b1;
            end
            if (r_gate_cnt == c_gate_last) r_state <= LATCH;
            else                           r_gate_cnt <= r_gate_cnt + 1'b1;
          end
        end
        LATCH: begin
          r_freq     <= r_edge_cnt;
          r_ovf      <= r_sat;
          r_valid    <= 1'b1;
          r_gate_cnt <= '0;
          // An edge in this cycle opens the next window so none is lost.
          r_edge_cnt <= {{(CNT_W-1){1'b0}}, w_rise};
          r_sat      <= 1'b0;
          r_state    <= bus.en ? GATE : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.freq_out = r_freq;
  assign bus.valid    = r_valid;
  assign bus.ovf      = r_ovf;

`ifdef FREQ_METER_PERIOD_EN
  logic [CNT_W-1:0] r_per_cnt;
  logic [CNT_W-1:0] r_period;
  logic             r_pvalid;
  logic             r_armed;

  always_ff @(posedge clk50M) begin
    if (!rst_n || r_state == IDLE) begin
      r_per_cnt <= '0;
      r_period  <= '0;
      r_pvalid  <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_pvalid <= 1'b0;
      if (w_rise) begin
        // First rise only arms; later rises publish the elapsed cycle count.
        r_per_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
        r_armed   <= 1'b1;
        if (r_armed) begin
          r_period <= r_per_cnt;
          r_pvalid <= 1'b1;
        end
      end else if (r_per_cnt != c_cnt_max) begin
        r_per_cnt <= r_per_cnt + 1'b1;
      end
    end
  end

  assign bus.period_out   = r_period;
  assign bus.period_valid = r_pvalid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_freq_meter.sv
`default_nettype none
// tb_freq_meter : two meters (CNT_W=8 and CNT_W=5) share one stimulus and are
// compared every cycle against a window-arithmetic reference model.
`timescale 1ns/1ps
module tb_freq_meter;

  localparam int G    = 100;
  localparam int NMAX = 8192;

  logic clk50M = 1'b0;
  logic rst_n  = 1'b0;
  logic en     = 1'b0;
  logic sig    = 1'b0;

  always #10 clk50M = ~clk50M;

  freq_meter_if #(.CNT_W(8)) if8 ();
  freq_meter_if #(.CNT_W(5)) if5 ();

  assign if8.en     = en;
  assign if8.sig_in = sig;
  assign if5.en     = en;
  assign if5.sig_in = sig;

  freq_meter #(.GATE_CYCLES(G), .CNT_W(8)) dut8 (.clk50M(clk50M), .rst_n(rst_n), .bus(if8.slave));
  freq_meter #(.GATE_CYCLES(G), .CNT_W(5)) dut5 (.clk50M(clk50M), .rst_n(rst_n), .bus(if5.slave));

  // Reference model state: sampled signal history and window bookkeeping.
  bit z [NMAX];
  int m = 0;
  bit counting = 0;
  int win_first = 0;
  int latch_at = 0;
  int exp_freq [2] = '{0, 0};
  int exp_ovf  [2] = '{0, 0};
  int exp_per  [2] = '{0, 0};
  bit armed = 0;
  int last_rise = 0;
  int v_e = 0;
  int pv_e = 0;

  int vectors = 0;
  int miscompares = 0;

  int mode = 1;
  int per = 10;
  bit tgt_on = 0;

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic int rise_at(int i);
    if (i < 3) return 0;
    return (z[i-2] && !z[i-3]) ? 1 : 0;
  endfunction

  function automatic bit next_sig(int k);
    bit s;
    if (mode == 0) s = ((k % per) < (per / 2));
    else           s = 1'($urandom_range(0, 1));
    if (tgt_on && counting) begin
      if (k == latch_at - 3)      s = 1'b0;
      else if (k == latch_at - 2) s = 1'b1;
    end
    return s;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d at edge %0d", tag, obs, exp, m);
    end
  endtask

  task automatic tick();
    bit r_smp;
    bit en_smp;
    bit s_smp;
    int rz;
    int sum;
    r_smp  = rst_n;
    en_smp = en;
    s_smp  = sig;
    @(posedge clk50M);
    #1;
    m++;
    v_e  = 0;
    pv_e = 0;
    if (!r_smp) begin
      z[m] = 1'b0;
      if (m >= 1) z[m-1] = 1'b0;
      if (m >= 2) z[m-2] = 1'b0;
      counting = 0;
      exp_freq = '{0, 0};
      exp_ovf  = '{0, 0};
      exp_per  = '{0, 0};
      armed    = 0;
    end else begin
      z[m] = s_smp;
      rz = rise_at(m);
      if (!counting) begin
        armed   = 0;
        exp_per = '{0, 0};
      end else if (rz != 0) begin
        if (armed) begin
          pv_e = 1;
          exp_per[0] = sat(m - last_rise, 255);
          exp_per[1] = sat(m - last_rise, 31);
        end
        armed = 1;
        last_rise = m;
      end
      if (!counting) begin
        if (en_smp) begin
          counting  = 1;
          win_first = m + 1;
          latch_at  = m + G + 1;
        end
      end else if (m == latch_at) begin
        sum = 0;
        for (int i = win_first; i < m; i++) sum += rise_at(i);
        v_e = 1;
        exp_freq[0] = sat(sum, 255);
        exp_ovf[0]  = (sum > 255) ? 1 : 0;
        exp_freq[1] = sat(sum, 31);
        exp_ovf[1]  = (sum > 31) ? 1 : 0;
        if (en_smp) begin
          win_first = m;
          latch_at  = m + G + 1;
        end else begin
          counting = 0;
        end
      end else if (!en_smp) begin
        counting = 0;
      end
    end
    check("freq8",  if8.freq_out, exp_freq[0]);
    check("valid8", if8.valid,    v_e);
    check("ovf8",   if8.ovf,      exp_ovf[0]);
    check("freq5",  if5.freq_out, exp_freq[1]);
    check("valid5", if5.valid,    v_e);
    check("ovf5",   if5.ovf,      exp_ovf[1]);
`ifdef FREQ_METER_PERIOD_EN
    check("per8",   if8.period_out,   exp_per[0]);
    check("pval8",  if8.period_valid, pv_e);
    check("per5",   if5.period_out,   exp_per[1]);
    check("pval5",  if5.period_valid, pv_e);
`endif
    sig = next_sig(m + 1);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_gate_left(int left);
    int n;
    n = 0;
    while (!(counting && (latch_at - m) == left) && n < 400) begin
      tick();
      n++;
    end
    check("gate_sync", (n < 400) ? 1 : 0, 1);
  endtask

  initial begin
    // Reset with sig_in toggling randomly.
    rst_n = 1'b0; en = 1'b0; mode = 1;
    run(3);
    rst_n = 1'b1;
    run(4);

    // Steady measurement, period 10.
    mode = 0; per = 10; en = 1'b1;
    run(5 * (G + 1) + 10);

    // Rise forced into each LATCH cycle for 5 windows.
    tgt_on = 1'b1;
    run(5 * (G + 1));
    tgt_on = 1'b0;

    // Saturation: toggle every cycle, then slow window clears ovf.
    per = 2;
    run(2 * (G + 1));
    per = 10;
    run(2 * (G + 1) + 5);

    // Abort mid-gate, then restart.
    wait_gate_left(51);
    en = 1'b0;
    run(12);
    en = 1'b1;
    run(2 * (G + 1) + 5);

    // Period 7, then reset mid-run.
    per = 7;
    run(150);
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1;
    run(250);

    // Random signal with occasional enable drops.
    mode = 1;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 79) == 0) en = ~en;
      tick();
    end
    en = 1'b1;
    run(G + 5);
    en = 1'b0;
    run(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
